// File: rtl/resp_misr_pkg.sv
// Shared types and default constants for the response MISR capture block.
package resp_misr_pkg;

    localparam int SIG_W  = 16;
    localparam int RESP_W = 7;

    localparam logic [SIG_W-1:0] DEF_POLY = 16'hB400;
    localparam logic [SIG_W-1:0] DEF_SEED = 16'h0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/resp_misr_step.sv
// One compaction step of the MISR: shift in the tap parity, then fold in the response.
module resp_misr_step #(
    parameter int SIG_W  = resp_misr_pkg::SIG_W,
    parameter int RESP_W = resp_misr_pkg::RESP_W,
    parameter logic [SIG_W-1:0] POLY = resp_misr_pkg::DEF_POLY
) (
    input  logic [SIG_W-1:0]  sig,
    input  logic [RESP_W-1:0] data,
    output logic [SIG_W-1:0]  sig_next
);

    logic fb;

    assign fb       = ^(sig & POLY);
    assign sig_next = {sig[SIG_W-2:0], fb} ^ SIG_W'(data);

endmodule

// File: rtl/resp_misr_capture.sv
// Compacts a run of upstream responses into a signature and compares it
// against a golden value latched when the run starts.
module resp_misr_capture #(
    parameter int SIG_W  = resp_misr_pkg::SIG_W,
    parameter int RESP_W = resp_misr_pkg::RESP_W,
    parameter logic [SIG_W-1:0] POLY = resp_misr_pkg::DEF_POLY,
    parameter logic [SIG_W-1:0] SEED = resp_misr_pkg::DEF_SEED
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [15:0]       pat_count,
    input  logic [SIG_W-1:0]  golden_sig,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [RESP_W-1:0] in_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [SIG_W-1:0]  sig,
    output logic [15:0]       accepted
);

    import resp_misr_pkg::*;

    state_t            state;
    state_t            state_next;
    logic [15:0]       count_q;
    logic [SIG_W-1:0]  golden_q;
    logic [SIG_W-1:0]  sig_step;
    logic [15:0]       accepted_inc;
    logic              load;
    logic              accept;

    resp_misr_step #(
        .SIG_W  (SIG_W),
        .RESP_W (RESP_W),
        .POLY   (POLY)
    ) u_step (
        .sig      (sig),
        .data     (in_data),
        .sig_next (sig_step)
    );

    assign accepted_inc = accepted + 16'd1;
    assign in_ready     = (state == RUN);
    assign busy         = (state == RUN);
    assign done         = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Abort outranks everything; start is only honoured outside RUN.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        accept     = 1'b0;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        load       = 1'b1;
                        state_next = (pat_count == 16'd0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (in_valid && in_ready) begin
                        accept = 1'b1;
                        if (accepted_inc == count_q) begin
                            state_next = DONE;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // pass is only ever set on the edge that enters DONE and cleared on any exit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig      <= '0;
            accepted <= '0;
            pass     <= 1'b0;
            count_q  <= '0;
            golden_q <= '0;
        end else if (load) begin
            sig      <= SEED;
            accepted <= '0;
            count_q  <= pat_count;
            golden_q <= golden_sig;
            pass     <= (pat_count == 16'd0) && (SEED == golden_sig);
        end else if (accept) begin
            sig      <= sig_step;
            accepted <= accepted_inc;
            pass     <= (accepted_inc == count_q) && (sig_step == golden_q);
        end else if (state_next != DONE) begin
            pass     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_resp_misr_capture.sv
// Randomised and directed checks of resp_misr_capture against a behavioural signature model.
module tb_resp_misr_capture;

    localparam logic [15:0] POLY_M = 16'hB400;
    localparam logic [15:0] SEED_M = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [15:0] pat_count;
    logic [15:0] golden_sig;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_data;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] sig;
    logic [15:0] accepted;

    int checks = 0;
    int errors = 0;

    logic [6:0] stim_q[$];
    bit         valid_pat[$];

    resp_misr_capture dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .pat_count  (pat_count),
        .golden_sig (golden_sig),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .sig        (sig),
        .accepted   (accepted)
    );

    always #5 clk = ~clk;

    // Signature of the first n queued responses: shift left, insert tap parity, xor response.
    function automatic logic [15:0] model_sig(input logic [15:0] seed, input int n);
        logic [15:0] s;
        logic [15:0] fb;
        s = seed;
        for (int i = 0; i < n; i++) begin
            fb = 16'($countones(s & POLY_M) % 2);
            s  = 16'(s << 1) | fb;
            s  = s ^ {9'd0, stim_q[i]};
        end
        return s;
    endfunction

    // Starts a run from the current negedge and feeds stim_q until cnt responses went in.
    task automatic run_stream(input logic [15:0] cnt, input logic [15:0] gold, input int gap_pct,
                              input bit noise, output int ready_bad, output bit timed_out);
        int idx;
        int cyc;
        bit v;
        idx = 0;
        cyc = 0;
        ready_bad = 0;
        timed_out = 0;
        start = 1'b1;
        pat_count = cnt;
        golden_sig = gold;
        @(negedge clk);
        start = 1'b0;
        while (idx < int'(cnt) && !timed_out) begin
            if (in_ready !== 1'b1) ready_bad++;
            if (valid_pat.size() > 0) v = valid_pat.pop_front();
            else v = ($urandom_range(99) >= gap_pct);
            in_valid = v;
            in_data = v ? stim_q[idx] : 7'($urandom);
            if (noise) begin
                pat_count = 16'($urandom);
                golden_sig = 16'($urandom);
                start = ($urandom_range(3) == 0);
            end
            @(negedge clk);
            if (v) idx++;
            cyc++;
            if (cyc > 4000) timed_out = 1;
        end
        in_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if ({busy, done, in_ready, pass, sig, accepted} !== 36'd0) begin
            errors++;
            $display("[TB] FAIL reset_hold: got busy=%b done=%b rdy=%b pass=%b sig=%h acc=%0d want all 0",
                     busy, done, in_ready, pass, sig, accepted);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, in_ready, pass, sig, accepted} !== 36'd0) begin
            errors++;
            $display("[TB] FAIL reset_release: got busy=%b done=%b rdy=%b pass=%b sig=%h acc=%0d want all 0",
                     busy, done, in_ready, pass, sig, accepted);
        end
    endtask

    task automatic test_single();
        int rb;
        bit to;
        stim_q = {7'h55};
        run_stream(16'd1, 16'h0055, 0, 0, rb, to);
        checks++;
        if (to || rb != 0) begin
            errors++;
            $display("[TB] FAIL single_flow: got timeout=%0b ready_low=%0d want 0 0", to, rb);
        end
        checks++;
        if ({done, busy, in_ready} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL single_done: got done/busy/rdy=%b want 100", {done, busy, in_ready});
        end
        checks++;
        if (sig !== 16'h0055 || pass !== 1'b1 || accepted !== 16'd1) begin
            errors++;
            $display("[TB] FAIL single_result: got sig=%h pass=%b acc=%0d want 0055 1 1", sig, pass, accepted);
        end
    endtask

    task automatic test_two();
        int rb;
        bit to;
        stim_q = {7'h55, 7'h00};
        run_stream(16'd2, 16'h00AA, 0, 0, rb, to);
        checks++;
        if (to || done !== 1'b1 || sig !== 16'h00AA || pass !== 1'b1 || accepted !== 16'd2) begin
            errors++;
            $display("[TB] FAIL two_pass: got to=%0b done=%b sig=%h pass=%b acc=%0d want 0 1 00aa 1 2",
                     to, done, sig, pass, accepted);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || sig !== 16'h00AA || pass !== 1'b1) begin
            errors++;
            $display("[TB] FAIL done_hold: got done=%b sig=%h pass=%b want 1 00aa 1", done, sig, pass);
        end
        run_stream(16'd2, 16'h00AB, 0, 0, rb, to);
        checks++;
        if (to || done !== 1'b1 || sig !== 16'h00AA || pass !== 1'b0) begin
            errors++;
            $display("[TB] FAIL two_fail: got to=%0b done=%b sig=%h pass=%b want 0 1 00aa 0", to, done, sig, pass);
        end
    endtask

    task automatic test_zero_count();
        logic [15:0] golds[2];
        golds[0] = SEED_M;
        golds[1] = SEED_M ^ 16'h0005;
        for (int k = 0; k < 2; k++) begin
            start = 1'b1;
            pat_count = 16'd0;
            golden_sig = golds[k];
            in_valid = 1'b1;
            @(negedge clk);
            start = 1'b0;
            checks++;
            if (done !== 1'b1 || in_ready !== 1'b0 || sig !== SEED_M || accepted !== 16'd0
                || pass !== (golds[k] == SEED_M)) begin
                errors++;
                $display("[TB] FAIL zero_count%0d: got done=%b rdy=%b sig=%h acc=%0d pass=%b want 1 0 %h 0 %b",
                         k, done, in_ready, sig, accepted, pass, SEED_M, golds[k] == SEED_M);
            end
            @(negedge clk);
            in_valid = 1'b0;
            checks++;
            if (in_ready !== 1'b0 || accepted !== 16'd0) begin
                errors++;
                $display("[TB] FAIL zero_count_idle%0d: got rdy=%b acc=%0d want 0 0", k, in_ready, accepted);
            end
        end
    endtask

    task automatic test_backpressure();
        int rb;
        bit to;
        logic [15:0] ref_sig;
        stim_q.delete();
        for (int i = 0; i < 3; i++) stim_q.push_back(7'($urandom));
        run_stream(16'd3, 16'h0000, 0, 0, rb, to);
        ref_sig = sig;
        checks++;
        if (to || ref_sig !== model_sig(SEED_M, 3)) begin
            errors++;
            $display("[TB] FAIL bp_nogap: got sig=%h want %h", ref_sig, model_sig(SEED_M, 3));
        end
        valid_pat = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        run_stream(16'd3, 16'h0000, 0, 0, rb, to);
        checks++;
        if (to || rb != 0 || done !== 1'b1 || sig !== ref_sig || accepted !== 16'd3) begin
            errors++;
            $display("[TB] FAIL bp_gaps: got to=%0b rdylow=%0d done=%b sig=%h acc=%0d want 0 0 1 %h 3",
                     to, rb, done, sig, accepted, ref_sig);
        end
    endtask

    task automatic test_abort();
        int rb;
        bit to;
        logic [15:0] held;
        stim_q.delete();
        for (int i = 0; i < 5; i++) stim_q.push_back(7'($urandom));
        start = 1'b1;
        pat_count = 16'd5;
        golden_sig = 16'h0000;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data = stim_q[i];
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data = stim_q[2];
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        checks++;
        if ({busy, done, in_ready, pass} !== 4'b0000 || sig !== model_sig(SEED_M, 2) || accepted !== 16'd2) begin
            errors++;
            $display("[TB] FAIL abort_run: got bdrp=%b sig=%h acc=%0d want 0000 %h 2",
                     {busy, done, in_ready, pass}, sig, accepted, model_sig(SEED_M, 2));
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_idle: got busy=%b done=%b want 0 0", busy, done);
        end
        run_stream(16'd1, model_sig(SEED_M, 1), 0, 0, rb, to);
        held = sig;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (to || done !== 1'b0 || pass !== 1'b0 || sig !== held || accepted !== 16'd1) begin
            errors++;
            $display("[TB] FAIL abort_done: got done=%b pass=%b sig=%h acc=%0d want 0 0 %h 1",
                     done, pass, sig, accepted, held);
        end
    endtask

    task automatic test_reset_mid_run();
        int rb;
        bit to;
        stim_q.delete();
        for (int i = 0; i < 4; i++) stim_q.push_back(7'($urandom));
        start = 1'b1;
        pat_count = 16'd4;
        golden_sig = 16'hFFFF;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data = stim_q[i];
            @(negedge clk);
        end
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++;
        if ({busy, done, in_ready, pass, sig, accepted} !== 36'd0) begin
            errors++;
            $display("[TB] FAIL reset_mid_run: got busy=%b done=%b rdy=%b pass=%b sig=%h acc=%0d want all 0",
                     busy, done, in_ready, pass, sig, accepted);
        end
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_wait: got busy=%b done=%b want 0 0", busy, done);
        end
        run_stream(16'd4, model_sig(SEED_M, 4), 20, 0, rb, to);
        checks++;
        if (to || done !== 1'b1 || sig !== model_sig(SEED_M, 4) || pass !== 1'b1 || accepted !== 16'd4) begin
            errors++;
            $display("[TB] FAIL reset_rerun: got done=%b sig=%h pass=%b acc=%0d want 1 %h 1 4",
                     done, sig, pass, accepted, model_sig(SEED_M, 4));
        end
    endtask

    task automatic test_random();
        int rb;
        bit to;
        int n;
        logic [15:0] exp_sig;
        logic [15:0] gold;
        for (int r = 0; r < 12; r++) begin
            n = $urandom_range(20, 1);
            stim_q.delete();
            for (int i = 0; i < n; i++) stim_q.push_back(7'($urandom));
            exp_sig = model_sig(SEED_M, n);
            gold = ($urandom_range(1) == 1) ? exp_sig : 16'($urandom);
            run_stream(16'(n), gold, 35, 1, rb, to);
            checks++;
            if (to || rb != 0 || done !== 1'b1 || busy !== 1'b0 || sig !== exp_sig
                || accepted !== 16'(n) || pass !== (gold == exp_sig)) begin
                errors++;
                $display("[TB] FAIL random%0d: got to=%0b rdylow=%0d done=%b sig=%h acc=%0d pass=%b want 0 0 1 %h %0d %b",
                         r, to, rb, done, sig, accepted, pass, exp_sig, n, gold == exp_sig);
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        pat_count = 16'd0;
        golden_sig = 16'd0;
        in_valid = 1'b0;
        in_data = 7'd0;
        @(negedge clk);
        test_reset();
        test_single();
        test_two();
        test_zero_count();
        test_backpressure();
        test_abort();
        test_reset_mid_run();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/resp_misr_capture.md
RESP_MISR_CAPTURE -- requirements
Module: resp_misr_capture

Interface
REQ-001 The block SHALL take parameter SIG_W, default 16: signature width.
REQ-002 The block SHALL take parameter RESP_W, default 7: response width, matching the 7 outputs of the upstream combinational cone.
REQ-003 The block SHALL take parameter POLY, default 16'hB400: feedback tap mask.
REQ-004 The block SHALL take parameter SEED, default 16'h0000: signature value loaded on start.
REQ-005 Ports (name, direction, width, meaning), one clock, asynchronous active-low reset:
 clk  in  1  sole clock, rising edge
 rst_n  in  1  asynchronous active-low reset
 start  in  1  one-cycle pulse that begins a capture run
 abort  in  1  forces return to IDLE
 pat_count  in  16  number of responses to compact in this run
 golden_sig  in  SIG_W  expected final signature
 in_valid  in  1  upstream response valid
 in_ready  out  1  block accepts a response this cycle
 in_data  in  RESP_W  response vector from the upstream cone
 busy  out  1  FSM in RUN
 done  out  1  FSM in DONE
 pass  out  1  final signature equals golden_sig, valid while done
 sig  out  SIG_W  current signature register
 accepted  out  16  responses accepted in the current run

Function
REQ-006 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-007 In IDLE, start SHALL set sig=SEED and accepted=0, latch pat_count and golden_sig, and go to RUN; if pat_count==0 it SHALL go directly to DONE instead.
REQ-008 in_ready SHALL equal (state==RUN); it SHALL be a combinational decode of registered state only, with no dependency on in_valid.
REQ-009 A response SHALL be accepted only on a cycle with in_valid && in_ready; only then SHALL sig and accepted update.
REQ-010 Signature update SHALL be: fb = XOR-reduce(sig & POLY); sig_next = {sig[SIG_W-2:0], fb} XOR zero-extended in_data.
REQ-011 accepted SHALL increment by 1 per accept and SHALL never wrap within a run.
REQ-012 The accept that makes accepted equal the latched count SHALL move RUN to DONE on that same edge; done SHALL be high on the following cycle (1-cycle latency).
REQ-013 pass SHALL be registered on entry to DONE as (sig_next == latched golden_sig), and SHALL be held constant throughout DONE.
REQ-014 In DONE, sig, accepted and pass SHALL hold; start SHALL restart exactly as in REQ-007.
REQ-015 start while in RUN SHALL be ignored.
REQ-016 abort SHALL move any state to IDLE on the next edge, with sig and accepted held; abort SHALL take priority over start and over an accept on the same cycle.
REQ-017 Changes to pat_count and golden_sig during RUN SHALL have no effect; only the values latched at start are used.
REQ-018 pass SHALL be 0 whenever done is 0.

Reset
REQ-019 rst_n low SHALL asynchronously force: state=IDLE, sig=0, accepted=0, pass=0, latched count=0 and latched golden=0; consequently in_ready=0, busy=0 and done=0.
REQ-020 Reset asserted mid-RUN SHALL discard the run; after release the block SHALL wait for a new start.
REQ-021 Release of rst_n SHALL be treated as synchronous to clk; no synchroniser is required inside the block.

Structure
REQ-022 Package resp_misr_pkg SHALL hold: the state enum (IDLE, RUN, DONE), SIG_W, RESP_W, and the default POLY and SEED constants.
REQ-023 Sub-module resp_misr_step SHALL implement the combinational REQ-010 next-signature function, parameterised by SIG_W, RESP_W and POLY.
REQ-024 All registers SHALL reside in resp_misr_capture; all outputs SHALL be registered or decoded from registered state.

Verification
REQ-025 The bench SHALL cover the following directed scenarios:
 Single pattern: SEED=0, pat_count=1, in_data=7'h55, golden=16'h0055 -> done one cycle after the accept, sig=16'h0055, pass=1, accepted=1.
 Two patterns 7'h55 then 7'h00, golden=16'h00AA -> sig=16'h00AA, pass=1; same run with golden=16'h00AB -> pass=0.
 Zero count: pat_count=0 with start -> DONE one cycle later, in_ready never high, sig=SEED, pass=(SEED==golden).
 Backpressure gaps: pat_count=3 with in_valid toggling 1,0,0,1,0,1 -> exactly 3 accepts, same sig as the gap-free run, accepted=3.
 abort and start asserted with an accept on the same cycle mid-run -> IDLE next cycle, no sig update, in_ready=0, done=0.
 rst_n pulsed low mid-RUN, asynchronously between clk edges -> all outputs 0 immediately; a fresh start then completes normally.
